// File: rtl/rgb_pwm_driver_if.sv
// Control/status bundle between the light sequencer and the RGB PWM driver.
interface rgb_pwm_driver_if #(
    parameter int PWM_BITS = 8
);
    logic                ena;
    logic [2:0]          rgb;
    logic [PWM_BITS-1:0] brightness;
    logic [2:0]          led_pwm;
    logic                busy;
    logic                period_strobe;

    modport master (
        output ena, rgb, brightness,
        input  led_pwm, busy, period_strobe
    );

    modport slave (
        input  ena, rgb, brightness,
        output led_pwm, busy, period_strobe
    );
endinterface

// File: rtl/rgb_pwm_driver.sv
// Three-channel LED PWM driver with per-channel linear duty ramping.
// Duty changes reach the LEDs only at PWM period boundaries, so every period is glitch-free.
module rgb_pwm_driver #(
    parameter int PWM_BITS   = 8,
    parameter int RAMP_TICKS = 1000
) (
    input  logic           clk,
    input  logic           rst,
    rgb_pwm_driver_if.slave bus
);
    localparam int                  PRE_W   = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam logic [PWM_BITS-1:0] CNT_MAX = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] ONE     = {{(PWM_BITS-1){1'b0}}, 1'b1};
    localparam logic [PRE_W-1:0]    PRE_MAX = PRE_W'(RAMP_TICKS - 1);
    localparam logic [PRE_W-1:0]    PRE_ONE = {{(PRE_W-1){1'b0}}, 1'b1};

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_UP   = 2'd1;
    localparam logic [1:0] ST_DOWN = 2'd2;

    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PRE_W-1:0]    pre_q, pre_d;
    logic [PWM_BITS-1:0] duty_q [3];
    logic [PWM_BITS-1:0] duty_d [3];
    logic [PWM_BITS-1:0] act_q  [3];
    logic [PWM_BITS-1:0] act_d  [3];
    logic [PWM_BITS-1:0] target [3];
    logic [1:0]          state  [3];
    logic [2:0]          led_q, led_d;
    logic                strobe;
    logic                tick;
    logic                busy_w;

    // Single saturating-free step: the ramp state already guarantees no overshoot or wrap.
    function automatic logic [PWM_BITS-1:0] step_duty(
        input logic [PWM_BITS-1:0] d,
        input logic [1:0]          st
    );
        logic [PWM_BITS-1:0] r;
        r = d;
        case (st)
            ST_UP:   r = d + ONE;
            ST_DOWN: r = d - ONE;
            default: r = d;
        endcase
        return r;
    endfunction

    always_comb begin
        strobe = bus.ena && (cnt_q == CNT_MAX);
        tick   = bus.ena && (pre_q == PRE_MAX);
        cnt_d  = bus.ena ? (cnt_q + ONE) : '0;
        pre_d  = (bus.ena && !tick) ? (pre_q + PRE_ONE) : '0;
        busy_w = 1'b0;
        led_d  = '0;
        for (int c = 0; c < 3; c++) begin
            target[c] = bus.rgb[c] ? bus.brightness : '0;
            if (duty_q[c] < target[c]) begin
                state[c] = ST_UP;
            end else if (duty_q[c] > target[c]) begin
                state[c] = ST_DOWN;
            end else begin
                state[c] = ST_IDLE;
            end
            busy_w = busy_w | (state[c] != ST_IDLE);
            if (!bus.ena) begin
                duty_d[c] = '0;
            end else if (tick) begin
                duty_d[c] = step_duty(duty_q[c], state[c]);
            end else begin
                duty_d[c] = duty_q[c];
            end
            // The strobe captures the pre-step duty even when a tick lands in the same cycle.
            if (!bus.ena) begin
                act_d[c] = '0;
            end else if (strobe) begin
                act_d[c] = duty_q[c];
            end else begin
                act_d[c] = act_q[c];
            end
            led_d[c] = bus.ena && (cnt_q < act_q[c]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            pre_q <= '0;
            led_q <= '0;
            for (int c = 0; c < 3; c++) begin
                duty_q[c] <= '0;
                act_q[c]  <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            pre_q <= pre_d;
            led_q <= led_d;
            for (int c = 0; c < 3; c++) begin
                duty_q[c] <= duty_d[c];
                act_q[c]  <= act_d[c];
            end
        end
    end

    assign bus.led_pwm       = led_q;
    assign bus.busy          = busy_w;
    assign bus.period_strobe = strobe;
endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Scoreboard bench for rgb_pwm_driver: per-period LED high counts and busy cycles.
module tb_rgb_pwm_driver;
    localparam int PB = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rgb_pwm_driver_if #(.PWM_BITS(PB)) pif ();

    rgb_pwm_driver #(.PWM_BITS(PB), .RAMP_TICKS(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (pif)
    );

    typedef struct {
        int r;
        int g;
        int b;
        int busy;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   acc_r, acc_g, acc_b, acc_busy, acc_cyc;

    function automatic void chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endfunction

    // Monitor: accumulate one PWM period, compare against the scoreboard on each strobe.
    always @(negedge clk) begin
        exp_t e;
        if (rst || !pif.ena) begin
            acc_r = 0; acc_g = 0; acc_b = 0; acc_busy = 0; acc_cyc = 0;
        end else begin
            acc_cyc++;
            acc_r    += int'(pif.led_pwm[2]);
            acc_g    += int'(pif.led_pwm[1]);
            acc_b    += int'(pif.led_pwm[0]);
            acc_busy += int'(pif.busy);
            if (pif.period_strobe) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("red_high_cycles",   acc_r,    e.r);
                    chk("green_high_cycles", acc_g,    e.g);
                    chk("blue_high_cycles",  acc_b,    e.b);
                    chk("busy_cycles",       acc_busy, e.busy);
                    chk("period_length",     acc_cyc,  16);
                end
                acc_r = 0; acc_g = 0; acc_b = 0; acc_busy = 0; acc_cyc = 0;
            end
        end
    end

    task automatic expect_period(input int r, input int g, input int b, input int bz);
        exp_t e;
        e.r = r; e.g = g; e.b = b; e.busy = bz;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic period(input int r, input int g, input int b, input int bz);
        expect_period(r, g, b, bz);
        cyc(16);
    endtask

    initial begin
        rst = 1'b1;
        pif.ena = 1'b1;
        pif.rgb = 3'b000;
        pif.brightness = '0;
        #12;
        chk("reset_led",    int'(pif.led_pwm), 0);
        chk("reset_strobe", int'(pif.period_strobe), 0);
        chk("reset_busy",   int'(pif.busy), 0);
        pif.rgb = 3'b100;
        pif.brightness = 4'd4;
        #1;
        chk("reset_busy_target", int'(pif.busy), 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Red ramps 0->4 in the first period.
        period(0, 0, 0, 8);
        period(4, 0, 0, 0);
        period(4, 0, 0, 0);

        // Red hands over to green concurrently.
        pif.rgb = 3'b010;
        period(4, 0, 0, 8);
        period(0, 4, 0, 0);

        // Red heads for 6 but is turned off at duty 2.
        pif.rgb = 3'b100;
        pif.brightness = 4'd6;
        expect_period(0, 4, 0, 8);
        cyc(4);
        pif.rgb = 3'b000;
        cyc(12);
        period(0, 0, 0, 0);

        // Full brightness on all channels.
        pif.brightness = 4'd15;
        pif.rgb = 3'b111;
        period(0, 0, 0, 16);
        period(7, 7, 7, 14);
        period(15, 15, 15, 0);
        period(15, 15, 15, 0);

        // Settle at duty 8, then drop and restore the enable.
        pif.brightness = 4'd8;
        period(15, 15, 15, 14);
        period(8, 8, 8, 0);
        cyc(5);
        pif.ena = 1'b0;
        cyc(1);
        chk("ena_off_led",    int'(pif.led_pwm), 0);
        chk("ena_off_busy",   int'(pif.busy), 1);
        chk("ena_off_strobe", int'(pif.period_strobe), 0);
        cyc(3);
        chk("ena_off_led_hold",    int'(pif.led_pwm), 0);
        chk("ena_off_strobe_hold", int'(pif.period_strobe), 0);
        pif.ena = 1'b1;
        period(0, 0, 0, 16);
        period(7, 7, 7, 0);
        period(8, 8, 8, 0);

        // Asynchronous reset pulse mid-period, mid-ramp.
        pif.rgb = 3'b010;
        pif.brightness = 4'd12;
        cyc(6);
        #2;
        chk("led_before_rst", int'(pif.led_pwm), 7);
        rst = 1'b1;
        #1;
        chk("rst_async_led",  int'(pif.led_pwm), 0);
        chk("rst_async_busy", int'(pif.busy), 1);
        @(posedge clk);
        #1;
        chk("rst_held_led",    int'(pif.led_pwm), 0);
        chk("rst_held_strobe", int'(pif.period_strobe), 0);
        rst = 1'b0;
        period(0, 0, 0, 16);
        period(0, 7, 0, 8);
        period(0, 12, 0, 0);

        cyc(2);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
